// File: rtl/flash_cmd_sequencer.sv
// flash_cmd_sequencer
// Follows the CPU's JEDEC unlock/command sequences to the PRG flash. Decides per
// cycle whether a CPU write may reach flash /WE. Tracks program/erase completion
// by DQ6 toggle polling, with a timeout.
// Optional build macro: FLASH_CMD_FILTER_EN. When it is defined, only writes
// that are the expected next step of a command sequence are passed to the flash.
//
// state | meaning
// IDLE  | no sequence in progress
// U1    | first unlock cycle seen (AA@A1)
// U2    | second unlock cycle seen (55@A2), waiting for the command byte
// PROG  | program command accepted, waiting for the data write
// E0    | erase setup (80) accepted, waiting for the second unlock AA
// EU1   | erase second unlock AA seen
// EU2   | erase second unlock 55 seen, waiting for 10 (chip) or 30 (sector)
// BUSY  | program/erase in flight, DQ6 toggle polling plus timeout
module flash_cmd_sequencer #(
  parameter logic [23:0] PROG_TIMEOUT  = 24'd1024,
  parameter logic [23:0] ERASE_TIMEOUT = 24'd16777215,
  parameter logic [11:0] UNLOCK_A1     = 12'hAAA,
  parameter logic [11:0] UNLOCK_A2     = 12'h555
) (
  input  logic        m2,
  input  logic        reset,
  input  logic        romsel,
  input  logic        cpu_rw_in,
  input  logic [14:0] cpu_addr_in,
  input  logic [7:0]  cpu_data_in,
  input  logic        prg_write_enabled,
  output logic        flash_we_allow,
  output logic        busy,
  output logic        op_done,
  output logic        error,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_U1   = 4'd1,
    S_U2   = 4'd2,
    S_PROG = 4'd3,
    S_E0   = 4'd4,
    S_EU1  = 4'd5,
    S_EU2  = 4'd6,
    S_BUSY = 4'd7
  } state_t;

  state_t      st;
  logic [23:0] counter;
  logic [23:0] limit_m1;
  logic        poll_valid;
  logic        dq6;
  logic        erase_op;
  logic        wr;
  logic        rd;
  logic        at_a1;
  logic        at_a2;
  logic        unused_addr_hi;

  assign wr             = ~romsel & ~cpu_rw_in;
  assign rd             = ~romsel & cpu_rw_in;
  assign at_a1          = (cpu_addr_in[11:0] == UNLOCK_A1);
  assign at_a2          = (cpu_addr_in[11:0] == UNLOCK_A2);
  assign unused_addr_hi = ^cpu_addr_in[14:12];
  assign limit_m1       = erase_op ? (ERASE_TIMEOUT - 24'd1) : (PROG_TIMEOUT - 24'd1);
  assign state          = st;
  assign busy           = (st == S_BUSY);

`ifdef FLASH_CMD_FILTER_EN
  logic step_ok;

  // Pass only the write that is the expected next step of the sequence in progress
  always_comb begin
    step_ok = 1'b0;
    case (st)
      S_IDLE:  step_ok = at_a1 && (cpu_data_in == 8'hAA);
      S_U1:    step_ok = at_a2 && (cpu_data_in == 8'h55);
      S_U2:    step_ok = at_a1 && ((cpu_data_in == 8'hA0) || (cpu_data_in == 8'h80));
      S_PROG:  step_ok = 1'b1;
      S_E0:    step_ok = at_a1 && (cpu_data_in == 8'hAA);
      S_EU1:   step_ok = at_a2 && (cpu_data_in == 8'h55);
      S_EU2:   step_ok = (at_a1 && (cpu_data_in == 8'h10)) || (cpu_data_in == 8'h30);
      default: step_ok = 1'b0;
    endcase
    // Reset (F0) is always allowed outside BUSY so software can recover the chip
    if ((st != S_BUSY) && (cpu_data_in == 8'hF0)) step_ok = 1'b1;
  end

  assign flash_we_allow = prg_write_enabled & step_ok & (st != S_BUSY);
`else
  assign flash_we_allow = prg_write_enabled & (st != S_BUSY);
`endif

  // Command-sequence FSM and completion tracking, all on the m2 falling edge
  always_ff @(negedge m2) begin
    if (reset) begin
      st         <= S_IDLE;
      op_done    <= 1'b0;
      error      <= 1'b0;
      counter    <= 24'd0;
      poll_valid <= 1'b0;
      dq6        <= 1'b0;
      erase_op   <= 1'b0;
    end else begin
      op_done <= 1'b0;
      case (st)
        S_IDLE: begin
          if (wr && prg_write_enabled && at_a1 && (cpu_data_in == 8'hAA)) begin
            st    <= S_U1;
            error <= 1'b0;
          end
        end
        S_BUSY: begin
          counter <= counter + 24'd1;
          // A completing poll wins over a timeout on the same cycle
          if (rd && poll_valid && (cpu_data_in[6] == dq6)) begin
            op_done <= 1'b1;
            st      <= S_IDLE;
          end else if (rd && poll_valid && cpu_data_in[5]) begin
            error <= 1'b1;
            st    <= S_IDLE;
          end else if (counter == limit_m1) begin
            error <= 1'b1;
            st    <= S_IDLE;
          end else if (rd) begin
            dq6        <= cpu_data_in[6];
            poll_valid <= 1'b1;
          end
        end
        default: begin
          if (!prg_write_enabled) begin
            st <= S_IDLE;
          end else if (wr && (cpu_data_in == 8'hF0)) begin
            st <= S_IDLE;
          end else if (wr) begin
            st <= S_IDLE;
            case (st)
              S_U1: if (at_a2 && (cpu_data_in == 8'h55)) st <= S_U2;
              S_U2: begin
                if (at_a1 && (cpu_data_in == 8'hA0)) st <= S_PROG;
                else if (at_a1 && (cpu_data_in == 8'h80)) st <= S_E0;
              end
              S_PROG: begin
                st         <= S_BUSY;
                erase_op   <= 1'b0;
                counter    <= 24'd0;
                poll_valid <= 1'b0;
              end
              S_E0:  if (at_a1 && (cpu_data_in == 8'hAA)) st <= S_EU1;
              S_EU1: if (at_a2 && (cpu_data_in == 8'h55)) st <= S_EU2;
              S_EU2: begin
                if ((at_a1 && (cpu_data_in == 8'h10)) || (cpu_data_in == 8'h30)) begin
                  st         <= S_BUSY;
                  erase_op   <= 1'b1;
                  counter    <= 24'd0;
                  poll_valid <= 1'b0;
                end
              end
              default: st <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Bench for flash_cmd_sequencer: scenario tasks with a scoreboard of expected
// {state, busy, op_done, error} per m2 cycle.
module tb_flash_cmd_sequencer;

  logic        m2 = 1'b0;
  logic        reset;
  logic        romsel;
  logic        cpu_rw_in;
  logic [14:0] cpu_addr_in;
  logic [7:0]  cpu_data_in;
  logic        prg_write_enabled;
  logic        flash_we_allow;
  logic        busy;
  logic        op_done;
  logic        error;
  logic [3:0]  state;

  int n_pass  = 0;
  int n_total = 0;

  logic [6:0] exp_q[$];

  typedef struct {
    logic        rs;
    logic        rw;
    logic        pwe;
    logic [14:0] a;
    logic [7:0]  d;
    logic [6:0]  e;
  } stim_t;

  localparam logic [3:0] IDLE = 4'd0, U1 = 4'd1, U2 = 4'd2, PROG = 4'd3,
                         E0 = 4'd4, EU1 = 4'd5, EU2 = 4'd6, BUSY = 4'd7;
  localparam logic [14:0] A1 = 15'h0AAA, A2 = 15'h0555;

  flash_cmd_sequencer dut (
    .m2                (m2),
    .reset             (reset),
    .romsel            (romsel),
    .cpu_rw_in         (cpu_rw_in),
    .cpu_addr_in       (cpu_addr_in),
    .cpu_data_in       (cpu_data_in),
    .prg_write_enabled (prg_write_enabled),
    .flash_we_allow    (flash_we_allow),
    .busy              (busy),
    .op_done           (op_done),
    .error             (error),
    .state             (state)
  );

  always #5 m2 = ~m2;

  function automatic logic [6:0] pk(input logic [3:0] s, input logic b, input logic o,
                                    input logic e);
    return {s, b, o, e};
  endfunction

  function automatic stim_t wr_(input logic [14:0] a, input logic [7:0] d, input logic [6:0] e);
    stim_t t;
    t.rs = 1'b0; t.rw = 1'b0; t.pwe = 1'b1; t.a = a; t.d = d; t.e = e;
    return t;
  endfunction

  function automatic stim_t rd_(input logic [7:0] d, input logic [6:0] e);
    stim_t t;
    t.rs = 1'b0; t.rw = 1'b1; t.pwe = 1'b1; t.a = 15'h0000; t.d = d; t.e = e;
    return t;
  endfunction

  function automatic stim_t idle_(input logic [6:0] e);
    stim_t t;
    t.rs = 1'b1; t.rw = 1'b1; t.pwe = 1'b1; t.a = 15'h0000; t.d = 8'h00; t.e = e;
    return t;
  endfunction

  // Drive a bus cycle while m2 is high, ahead of the sampling falling edge
  task automatic setup(input logic rs, input logic rw, input logic pwe,
                       input logic [14:0] a, input logic [7:0] d);
    @(posedge m2);
    romsel = rs; cpu_rw_in = rw; prg_write_enabled = pwe;
    cpu_addr_in = a; cpu_data_in = d;
    #1;
  endtask

  task automatic tick();
    @(negedge m2);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    reset = 1'b1;
    setup(1'b1, 1'b1, 1'b1, 15'h0, 8'h0);
    tick();
    setup(1'b1, 1'b1, 1'b1, 15'h0, 8'h0);
    tick();
    got = {state, busy, op_done, error};
    n_total++;
    if (got !== pk(IDLE, 0, 0, 0)) $display("FAIL reset_outputs: got %h expected %h", got, pk(IDLE, 0, 0, 0));
    else n_pass++;
    n_total++;
    if (dut.counter !== 24'd0) $display("FAIL reset_counter: got %0d expected 0", dut.counter);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_program();
    stim_t s[$];
    logic [6:0] got, exp;
    s.push_back(wr_(A1, 8'hAA, pk(U1, 0, 0, 0)));
    s.push_back(wr_(A2, 8'h55, pk(U2, 0, 0, 0)));
    s.push_back(wr_(A1, 8'hA0, pk(PROG, 0, 0, 0)));
    s.push_back(wr_(15'h1234, 8'h5A, pk(BUSY, 1, 0, 0)));
    s.push_back(rd_(8'h40, pk(BUSY, 1, 0, 0)));
    s.push_back(rd_(8'h00, pk(BUSY, 1, 0, 0)));
    s.push_back(rd_(8'h00, pk(IDLE, 0, 1, 0)));
    s.push_back(idle_(pk(IDLE, 0, 0, 0)));
    foreach (s[i]) begin
      setup(s[i].rs, s[i].rw, s[i].pwe, s[i].a, s[i].d);
      exp_q.push_back(s[i].e);
      tick();
      got = {state, busy, op_done, error};
      exp = exp_q.pop_front();
      n_total++;
      if (got !== exp) $display("FAIL program[%0d]: got %h expected %h", i, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_sector_erase();
    stim_t s[$];
    logic [6:0] got, exp;
    s.push_back(wr_(A1, 8'hAA, pk(U1, 0, 0, 0)));
    s.push_back(wr_(A2, 8'h55, pk(U2, 0, 0, 0)));
    s.push_back(wr_(A1, 8'h80, pk(E0, 0, 0, 0)));
    s.push_back(wr_(A1, 8'hAA, pk(EU1, 0, 0, 0)));
    s.push_back(wr_(A2, 8'h55, pk(EU2, 0, 0, 0)));
    s.push_back(wr_(15'h4000, 8'h30, pk(BUSY, 1, 0, 0)));
    s.push_back(wr_(15'h0000, 8'h00, pk(BUSY, 1, 0, 0)));
    s.push_back(rd_(8'h40, pk(BUSY, 1, 0, 0)));
    s.push_back(rd_(8'h20, pk(IDLE, 0, 0, 1)));
    s.push_back(idle_(pk(IDLE, 0, 0, 1)));
    s.push_back(wr_(A1, 8'hAA, pk(U1, 0, 0, 0)));
    s.push_back(wr_(A2, 8'hF0, pk(IDLE, 0, 0, 0)));
    foreach (s[i]) begin
      setup(s[i].rs, s[i].rw, s[i].pwe, s[i].a, s[i].d);
      exp_q.push_back(s[i].e);
      tick();
      got = {state, busy, op_done, error};
      exp = exp_q.pop_front();
      n_total++;
      if (got !== exp) $display("FAIL sector_erase[%0d]: got %h expected %h", i, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    stim_t s[$];
    logic [6:0] got, exp;
    // Unpolled program: error exactly on the 1024th edge after entering BUSY
    s.push_back(wr_(A1, 8'hAA, pk(U1, 0, 0, 0)));
    s.push_back(wr_(A2, 8'h55, pk(U2, 0, 0, 0)));
    s.push_back(wr_(A1, 8'hA0, pk(PROG, 0, 0, 0)));
    s.push_back(wr_(15'h0100, 8'h12, pk(BUSY, 1, 0, 0)));
    for (int k = 1; k < 1024; k++) s.push_back(idle_(pk(BUSY, 1, 0, 0)));
    s.push_back(idle_(pk(IDLE, 0, 0, 1)));
    // Completing poll on the limit cycle wins over the timeout
    s.push_back(wr_(A1, 8'hAA, pk(U1, 0, 0, 0)));
    s.push_back(wr_(A2, 8'h55, pk(U2, 0, 0, 0)));
    s.push_back(wr_(A1, 8'hA0, pk(PROG, 0, 0, 0)));
    s.push_back(wr_(15'h0100, 8'h12, pk(BUSY, 1, 0, 0)));
    s.push_back(rd_(8'h40, pk(BUSY, 1, 0, 0)));
    for (int k = 2; k < 1024; k++) s.push_back(idle_(pk(BUSY, 1, 0, 0)));
    s.push_back(rd_(8'h40, pk(IDLE, 0, 1, 0)));
    foreach (s[i]) begin
      setup(s[i].rs, s[i].rw, s[i].pwe, s[i].a, s[i].d);
      exp_q.push_back(s[i].e);
      tick();
      got = {state, busy, op_done, error};
      exp = exp_q.pop_front();
      n_total++;
      if (got !== exp) $display("FAIL timeout[%0d]: got %h expected %h", i, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    stim_t s[$];
    stim_t t;
    logic [6:0] got, exp;
    s.push_back(wr_(A1, 8'hAA, pk(U1, 0, 0, 0)));
    s.push_back(wr_(A2, 8'h55, pk(U2, 0, 0, 0)));
    s.push_back(wr_(A1, 8'h12, pk(IDLE, 0, 0, 0)));
    s.push_back(wr_(A1, 8'hAA, pk(U1, 0, 0, 0)));
    s.push_back(wr_(A2, 8'h55, pk(U2, 0, 0, 0)));
    s.push_back(wr_(A1, 8'hF0, pk(IDLE, 0, 0, 0)));
    s.push_back(wr_(A1, 8'hAA, pk(U1, 0, 0, 0)));
    s.push_back(idle_(pk(U1, 0, 0, 0)));
    s.push_back(wr_(A2, 8'h55, pk(U2, 0, 0, 0)));
    t = rd_(8'h00, pk(IDLE, 0, 0, 0));
    t.pwe = 1'b0;
    s.push_back(t);
    s.push_back(wr_(A1, 8'hAA, pk(U1, 0, 0, 0)));
    s.push_back(wr_(A1, 8'h55, pk(IDLE, 0, 0, 0)));
    foreach (s[i]) begin
      setup(s[i].rs, s[i].rw, s[i].pwe, s[i].a, s[i].d);
      exp_q.push_back(s[i].e);
      tick();
      got = {state, busy, op_done, error};
      exp = exp_q.pop_front();
      n_total++;
      if (got !== exp) $display("FAIL abort[%0d]: got %h expected %h", i, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_gating();
    stim_t s[$];
    logic [6:0] got, exp;
    logic stray_exp;
`ifdef FLASH_CMD_FILTER_EN
    stray_exp = 1'b0;
`else
    stray_exp = 1'b1;
`endif
    // Chip erase into BUSY
    s.push_back(wr_(A1, 8'hAA, pk(U1, 0, 0, 0)));
    s.push_back(wr_(A2, 8'h55, pk(U2, 0, 0, 0)));
    s.push_back(wr_(A1, 8'h80, pk(E0, 0, 0, 0)));
    s.push_back(wr_(A1, 8'hAA, pk(EU1, 0, 0, 0)));
    s.push_back(wr_(A2, 8'h55, pk(EU2, 0, 0, 0)));
    s.push_back(wr_(A1, 8'h10, pk(BUSY, 1, 0, 0)));
    foreach (s[i]) begin
      setup(s[i].rs, s[i].rw, s[i].pwe, s[i].a, s[i].d);
      exp_q.push_back(s[i].e);
      tick();
      got = {state, busy, op_done, error};
      exp = exp_q.pop_front();
      n_total++;
      if (got !== exp) $display("FAIL chip_erase[%0d]: got %h expected %h", i, got, exp);
      else n_pass++;
    end
    setup(1'b0, 1'b0, 1'b1, 15'h0000, 8'h00);
    n_total++;
    if (flash_we_allow !== 1'b0) $display("FAIL allow_busy: got %b expected 0", flash_we_allow);
    else n_pass++;
    tick();
    // Counter has run one edge since entry; let it reach 500 then reset
    for (int k = 1; k < 500; k++) begin
      setup(1'b1, 1'b1, 1'b1, 15'h0, 8'h0);
      tick();
    end
    n_total++;
    if (dut.counter !== 24'd500 || busy !== 1'b1)
      $display("FAIL counter_500: got %0d busy=%b expected 500 busy=1", dut.counter, busy);
    else n_pass++;
    reset = 1'b1;
    setup(1'b1, 1'b1, 1'b1, 15'h0, 8'h0);
    tick();
    reset = 1'b0;
    got = {state, busy, op_done, error};
    n_total++;
    if (got !== pk(IDLE, 0, 0, 0) || dut.counter !== 24'd0)
      $display("FAIL reset_mid_busy: got %h counter=%0d expected %h counter=0", got, dut.counter, pk(IDLE, 0, 0, 0));
    else n_pass++;
    setup(1'b0, 1'b0, 1'b1, 15'h0000, 8'h00);
    n_total++;
    if (flash_we_allow !== stray_exp) $display("FAIL allow_stray: got %b expected %b", flash_we_allow, stray_exp);
    else n_pass++;
    setup(1'b0, 1'b0, 1'b1, A1, 8'hAA);
    n_total++;
    if (flash_we_allow !== 1'b1) $display("FAIL allow_unlock: got %b expected 1", flash_we_allow);
    else n_pass++;
    tick();
    setup(1'b0, 1'b0, 1'b0, A2, 8'h55);
    n_total++;
    if (flash_we_allow !== 1'b0) $display("FAIL allow_pwe_low: got %b expected 0", flash_we_allow);
    else n_pass++;
    tick();
    n_total++;
    if (state !== IDLE) $display("FAIL pwe_low_abort: got %0d expected 0", state);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1; romsel = 1'b1; cpu_rw_in = 1'b1; cpu_addr_in = '0;
    cpu_data_in = '0; prg_write_enabled = 1'b1;
    test_reset();
    test_program();
    test_sector_erase();
    test_timeout();
    test_abort();
    test_gating();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/flash_cmd_sequencer.md
# flash_cmd_sequencer

- Tracks the CPU's JEDEC command sequences to the PRG flash and decides, per CPU cycle, whether a CPU write may reach the flash /WE pin.
- Watches program/erase completion using DQ6 toggle polling, with a timeout.
- Sits between the CPU bus inputs and the cartridge's flash_we generation; its flash_we_allow output replaces the raw prg_write_enabled term.

## Interface
- PROG_TIMEOUT, 24'd1024: m2 cycles allowed for a program operation (~0.57 ms).
- ERASE_TIMEOUT, 24'd16777215: m2 cycles allowed for an erase operation (~9.4 s).
- UNLOCK_A1, 12'hAAA: cpu_addr_in[11:0] for unlock cycle 1 (x8 mode).
- UNLOCK_A2, 12'h555: cpu_addr_in[11:0] for unlock cycle 2.
- m2  in  1  CPU M2; the only clock; all state updates on the falling edge.
- reset  in  1  synchronous, active-high; sampled on the m2 falling edge.
- romsel  in  1  active-low ROM select; flash access = ~romsel.
- cpu_rw_in  in  1  1 = read, 0 = write.
- cpu_addr_in  in  15  CPU address bits 14:0.
- cpu_data_in  in  8  CPU data bus, sampled at the m2 falling edge.
- prg_write_enabled  in  1  mapper-level flash write enable.
- flash_we_allow  out  1  combinational; 1 = the current write may assert flash /WE.
- busy  out  1  a program/erase is in flight.
- op_done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky timeout/DQ5 failure flag.
- state  out  4  current FSM state, for debug.

## Operation
- Event definitions, taken at the m2 falling edge:
  - WR = ~romsel & ~cpu_rw_in.
  - RD = ~romsel & cpu_rw_in.
  - Non-flash cycles never change state, except for the BUSY timeout counting.
- States: IDLE(0), U1(1), U2(2), PROG(3), E0(4), EU1(5), EU2(6), BUSY(7).
- Unlock and command path:
  - IDLE: WR of AA at UNLOCK_A1 while prg_write_enabled -> U1; clears error.
  - U1: WR of 55 at UNLOCK_A2 -> U2.
  - U2 with WR at UNLOCK_A1: A0 -> PROG; 80 -> E0; F0 -> IDLE.
- Program: PROG: any WR (data, any address) -> BUSY, with timeout limit PROG_TIMEOUT.
- Erase path:
  - E0: WR AA at UNLOCK_A1 -> EU1.
  - EU1: WR 55 at UNLOCK_A2 -> EU2.
  - EU2: WR 10 at UNLOCK_A1 (chip erase) or WR 30 at any address (sector erase) -> BUSY, with limit ERASE_TIMEOUT.
- Sequence errors:
  - In U1..EU2, any other WR -> IDLE.
  - A WR of F0 in any non-BUSY state -> IDLE.
  - prg_write_enabled=0 in U1..EU2 -> IDLE.
- BUSY, toggle polling:
  - Counter increments every m2 cycle.
  - First RD stores dq6 and sets the poll_valid flag.
  - Each later RD compares cpu_data_in[6] with the stored dq6:
    - equal -> op_done=1 for one cycle, -> IDLE;
    - differs and cpu_data_in[5]=1 -> error=1, -> IDLE;
    - otherwise store the new dq6.
  - Counter reaches the limit with no completion -> error=1, -> IDLE.
  - WR in BUSY: ignored by the FSM.
- flash_we_allow (default build) = prg_write_enabled & (state != BUSY).
- busy = (state == BUSY).
- Width rules: 24-bit counter, cleared on entry to BUSY; the limit compare is counter == limit-1.

## Timing
- Reset values: state=IDLE, busy=0, op_done=0, error=0, counter=0, poll_valid=0.
- Reset mid-BUSY aborts tracking only; the flash itself is not commanded.
- Latency:
  - flash_we_allow is zero-latency combinational from the registered state.
  - busy rises on the m2 falling edge that samples the final command write.
  - op_done and error update on the m2 falling edge of the completing RD or the timeout cycle.
- Simultaneous events:
  - The timeout-limit cycle coinciding with a completing RD -> completion wins (op_done, no error).
  - reset has priority over everything.
- A BUSY timeout with zero RDs (CPU never polls) -> error.

## Configuration
- FLASH_CMD_FILTER_EN:
  - When defined, flash_we_allow is 1 only for writes that match the expected next step of a valid sequence: IDLE AA@A1, U1 55@A2, U2 A0/80/F0@A1, PROG any, E0 AA@A1, EU1 55@A2, EU2 10@A1 or 30@any, plus F0 anywhere outside BUSY. Stray game writes to $8000-$FFFF never reach the flash.
  - When undefined, the default formula above applies.
  - FSM behaviour is identical either way.

## Test plan
- Program: WR AA@$8AAA, 55@$8555, A0@$8AAA, 5A@$9234 -> busy=1 after the 4th edge; RD sequence DQ6=1,0,0 -> op_done pulse on the 3rd RD, busy=0, error=0.
- Sector erase: AA, 55, 80, AA, 55, 30@$C000 -> BUSY; RDs alternate DQ6 with DQ5=1 on the 2nd RD -> error=1, IDLE; next AA@$8AAA clears error.
- Timeout: program sequence, then no RDs for 1024 m2 cycles -> error=1, state=IDLE exactly at cycle 1024.
- Abort: AA, 55, then 12@$8AAA -> IDLE; AA, 55, F0 -> IDLE; prg_write_enabled deasserted in U2 -> IDLE next edge.
- Gating: in BUSY, WR to $8000 -> flash_we_allow=0. With FLASH_CMD_FILTER_EN, WR 00@$8000 in IDLE -> flash_we_allow=0; without the macro -> 1.
- Reset mid-BUSY with counter=500 -> state=IDLE, busy=0, counter=0, error=0 on the same edge.
